// File: rtl/riscv_regfile_mp.sv
// Multi-read-port RV32I integer register file with reset sweep, optional x0 and write bypass.
// state | meaning
// INIT  | clearing one register per cycle, reads forced to 0, writes ignored
// READY | sweep done, normal write/read operation
module riscv_regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   regWrite,
  input  logic [AW-1:0]          rd,
  input  logic [XLEN-1:0]        data,
  input  logic [NUM_RD*AW-1:0]   rs,
  output logic [NUM_RD*XLEN-1:0] rdata,
  output logic                   ready
);

  typedef enum logic {INIT = 1'b0, READY = 1'b1} state_t;

  localparam logic [AW:0] LAST = (AW+1)'(NREGS - 1);

  state_t          state_q, state_d;
  logic [AW:0]     idx_q, idx_d;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_drop;
  logic            wr_en;

  always_ff @(posedge clk) begin
    state_q <= state_d;
    idx_q   <= idx_d;
  end

  // idx parks at NREGS once READY; the extra bit keeps it from wrapping back to 0
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == INIT) begin
      idx_d = idx_q + 1'b1;
      if (idx_q == LAST) state_d = READY;
    end
    if (rst) begin
      state_d = INIT;
      idx_d   = '0;
    end
  end

  assign ready   = (state_q == READY);
  assign wr_drop = (ZERO_REG != 0) && (rd == '0);
  assign wr_en   = (state_q == READY) && regWrite && !wr_drop;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == INIT) regs[idx_q[AW-1:0]] <= '0;
      else if (wr_en)      regs[rd] <= data;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] val;

    assign addr = rs[i*AW +: AW];

    always_comb begin
      val = regs[addr];
      if (state_q == INIT || (ZERO_REG != 0 && addr == '0))
        val = '0;
      else if (BYPASS != 0 && wr_en && rd == addr)
        val = data;
    end

    assign rdata[i*XLEN +: XLEN] = val;
  end

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Checks two register file configurations against a behavioural model every cycle plus directed cases.
module tb_riscv_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // instance A: XLEN=32 NREGS=32 NUM_RD=2 BYPASS=1 ZERO_REG=1
  logic        wa;
  logic [4:0]  rda;
  logic [31:0] da;
  logic [9:0]  rsa;
  logic [63:0] rdata_a;
  logic        ready_a;

  // instance B: XLEN=64 NREGS=16 NUM_RD=3 BYPASS=0 ZERO_REG=0
  logic         wb;
  logic [3:0]   rdb;
  logic [63:0]  db;
  logic [11:0]  rsb;
  logic [191:0] rdata_b;
  logic         ready_b;

  riscv_regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_a (
    .clk(clk), .rst(rst), .regWrite(wa), .rd(rda), .data(da), .rs(rsa),
    .rdata(rdata_a), .ready(ready_a)
  );

  riscv_regfile_mp #(.XLEN(64), .NREGS(16), .NUM_RD(3), .BYPASS(0), .ZERO_REG(0)) u_b (
    .clk(clk), .rst(rst), .regWrite(wb), .rd(rdb), .data(db), .rs(rsb),
    .rdata(rdata_b), .ready(ready_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: cycles since the last reset edge (saturating at NREGS) plus plain storage arrays.
  int          cnt_a, cnt_b;
  bit          model_on = 1'b0;
  logic [31:0] mem_a [32];
  logic [63:0] mem_b [16];

  always @(posedge clk) begin
    if (rst) begin
      model_on <= 1'b1;
      cnt_a    <= 0;
      cnt_b    <= 0;
      for (int k = 0; k < 32; k++) mem_a[k] <= '0;
      for (int k = 0; k < 16; k++) mem_b[k] <= '0;
    end else begin
      if (cnt_a < 32) cnt_a <= cnt_a + 1;
      else if (wa && rda != 5'd0) mem_a[rda] <= da;
      if (cnt_b < 16) cnt_b <= cnt_b + 1;
      else if (wb) mem_b[rdb] <= db;
    end
  end

  function automatic logic [31:0] exp_a(input int p);
    logic [4:0] a;
    a = rsa[p*5 +: 5];
    if (cnt_a != 32) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (wa && rda == a) return da;
    return mem_a[a];
  endfunction

  function automatic logic [63:0] exp_b(input int p);
    logic [3:0] a;
    a = rsb[p*4 +: 4];
    if (cnt_b != 16) return 64'd0;
    return mem_b[a];
  endfunction

  always @(negedge clk) begin
    if (model_on) begin
      chk("ready_a", {63'd0, ready_a}, {63'd0, cnt_a == 32});
      chk("ready_b", {63'd0, ready_b}, {63'd0, cnt_b == 16});
      for (int p = 0; p < 2; p++)
        chk($sformatf("a_port%0d", p), {32'd0, rdata_a[p*32 +: 32]}, {32'd0, exp_a(p)});
      for (int p = 0; p < 3; p++)
        chk($sformatf("b_port%0d", p), rdata_b[p*64 +: 64], exp_b(p));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  int na, nb;

  initial begin
    rst = 1'b1;
    wa = 1'b0; rda = '0; da = '0; rsa = '0;
    wb = 1'b0; rdb = '0; db = '0; rsb = '0;
    tick; tick;
    rst = 1'b0;

    // sweep length, with random traffic that must not disturb the sweep
    na = 0; nb = 0;
    for (int c = 1; c <= 40; c++) begin
      wa = $urandom; rda = 5'($urandom); da = $urandom; rsa = 10'($urandom);
      wb = $urandom; rdb = 4'($urandom); db = {$urandom, $urandom}; rsb = 12'($urandom);
      tick;
      if (ready_a && na == 0) na = c;
      if (ready_b && nb == 0) nb = c;
    end
    chk("sweep_len_a", 64'(na), 64'd32);
    chk("sweep_len_b", 64'(nb), 64'd16);
    wa = 1'b0; wb = 1'b0;

    // write x1=10, x2=10 and read back
    wa = 1'b1; rda = 5'd1; da = 32'd10; tick;
    rda = 5'd2; tick;
    wa = 1'b0; rsa = {5'd2, 5'd1}; #1;
    chk("t2_rd0", {32'd0, rdata_a[31:0]}, 64'd10);
    chk("t2_rd1", {32'd0, rdata_a[63:32]}, 64'd10);
    rsa = {5'd2, 5'd0}; #1;
    chk("t2_x0", {32'd0, rdata_a[31:0]}, 64'd0);

    // bypass on A, none on B
    wa = 1'b1; rda = 5'd1; da = 32'd15; rsa = {5'd0, 5'd1};
    wb = 1'b1; rdb = 4'd1; db = 64'd10; tick;
    db = 64'd15; rsb = {4'd0, 4'd0, 4'd1}; wa = 1'b0; #1;
    chk("t3_a_stored", {32'd0, rdata_a[31:0]}, 64'd15);
    chk("t3_b_old", rdata_b[63:0], 64'd10);
    wa = 1'b1; rda = 5'd1; da = 32'd21; #1;
    chk("t3_a_bypass", {32'd0, rdata_a[31:0]}, 64'd21);
    tick;
    wa = 1'b0; wb = 1'b0; #1;
    chk("t3_b_next", rdata_b[63:0], 64'd15);

    // x0 writes
    wa = 1'b1; rda = 5'd0; da = 32'hDEADBEEF; rsa = '0;
    wb = 1'b1; rdb = 4'd0; db = 64'hDEADBEEF; rsb = '0; #1;
    chk("t4_a_x0_same", {32'd0, rdata_a[31:0]}, 64'd0);
    tick;
    wa = 1'b0; wb = 1'b0; #1;
    chk("t4_a_x0", {32'd0, rdata_a[31:0]}, 64'd0);
    chk("t4_b_x0", rdata_b[63:0], 64'h00000000DEADBEEF);

    // all B ports on one register
    wb = 1'b1; rdb = 4'd15; db = 64'h0123456789ABCDEF; tick;
    wb = 1'b0; rsb = {4'd15, 4'd15, 4'd15}; #1;
    chk("t6_p0", rdata_b[63:0],    64'h0123456789ABCDEF);
    chk("t6_p1", rdata_b[127:64],  64'h0123456789ABCDEF);
    chk("t6_p2", rdata_b[191:128], 64'h0123456789ABCDEF);

    // random traffic with narrow addresses to force collisions
    for (int c = 0; c < 400; c++) begin
      wa = $urandom; rda = 5'($urandom_range(0, 7)); da = $urandom;
      rsa = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wb = $urandom; rdb = 4'($urandom_range(0, 5)); db = {$urandom, $urandom};
      rsb = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      tick;
    end
    wa = 1'b0; wb = 1'b0;

    // reset in the middle of a sweep
    wa = 1'b1; rda = 5'd5; da = 32'd7; tick;
    wa = 1'b0; rsa = {5'd0, 5'd5}; #1;
    chk("t5_x5_before", {32'd0, rdata_a[31:0]}, 64'd7);
    rst = 1'b1; tick;
    rst = 1'b0;
    repeat (10) tick;
    rst = 1'b1; tick;
    rst = 1'b0;
    na = 0; nb = 0;
    for (int c = 1; c <= 40; c++) begin
      wa = !ready_a; rda = 5'd5; da = 32'd99;
      wb = !ready_b; rdb = 4'd5; db = 64'd99; rsb = {4'd5, 4'd5, 4'd5};
      tick;
      if (ready_a && na == 0) na = c;
      if (ready_b && nb == 0) nb = c;
    end
    wa = 1'b0; wb = 1'b0; #1;
    chk("t5_sweep_len_a", 64'(na), 64'd32);
    chk("t5_sweep_len_b", 64'(nb), 64'd16);
    chk("t5_x5_cleared", {32'd0, rdata_a[31:0]}, 64'd0);
    chk("t5_b_x5_cleared", rdata_b[63:0], 64'd0);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
